// File: rtl/emb_seq_block.sv
// emb_seq_block
//   Embedding lookup for a short token sequence. SEQ_LEN character codes are
//   latched at start, then one embedding element per cycle is read from an
//   external synchronous ROM and assembled into a flat output vector.
//
//   Ports:
//     clk, rst    single rising-edge clock, synchronous active-high reset
//     run         level request: high starts/holds a lookup, low aborts/clears
//     d           SEQ_LEN packed character codes, token t at d[t*CHAR_LEN +: CHAR_LEN]
//     rom_addr    registered ROM address
//     rom_q       ROM data, valid ROM_LAT cycles after rom_addr
//     busy        lookup in progress (FETCH or DRAIN)
//     valid       q/err complete and stable (DONE)
//     err         bit t set when token t is out of range (>= VOCAB)
//     q           element k of token t at q[(t*EMB_DIM+k)*N_LEN +: N_LEN]
//     state_dbg   current FSM state (IDLE=0, FETCH=1, DRAIN=2, DONE=3)
//
//   Handshake: run is a level. A lookup begins on the edge that samples run=1
//   in IDLE; valid stays high in DONE for as long as run stays high; dropping
//   run from any state returns to IDLE on the next edge.
module emb_seq_block #(
    parameter int CHAR_LEN = 8,
    parameter int EMB_DIM  = 24,
    parameter int N_LEN    = 16,
    parameter int SEQ_LEN  = 4,
    parameter int VOCAB    = 200,
    parameter int PAD_ID   = 0,
    parameter int ROM_LAT  = 1,
    parameter int ADDR_W   = 13
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                run,
    input  logic [SEQ_LEN*CHAR_LEN-1:0]         d,
    output logic [ADDR_W-1:0]                   rom_addr,
    input  logic [N_LEN-1:0]                    rom_q,
    output logic                                busy,
    output logic                                valid,
    output logic [SEQ_LEN-1:0]                  err,
    output logic [SEQ_LEN*EMB_DIM*N_LEN-1:0]    q,
    output logic [1:0]                          state_dbg
);

    localparam int N     = SEQ_LEN * EMB_DIM;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int T_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int K_W   = (EMB_DIM > 1) ? $clog2(EMB_DIM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [K_W-1:0]   LAST_K   = K_W'(EMB_DIM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_n;

    function automatic logic tok_is_err(input logic [CHAR_LEN-1:0] tok);
        return 32'(tok) >= VOCAB;
    endfunction

    function automatic logic tok_is_zero(input logic [CHAR_LEN-1:0] tok);
        return (32'(tok) >= VOCAB) || (32'(tok) == PAD_ID);
    endfunction

    // Latched tokens and the counters describing the index currently on rom_addr.
    logic [CHAR_LEN-1:0] tok_r [SEQ_LEN];
    logic [IDX_W-1:0]    cur_idx;
    logic [T_W-1:0]      cur_t;
    logic [K_W-1:0]      cur_k;
    logic                iss_vld;
    logic                iss_zero;

    // Tag pipe that travels alongside the ROM latency; stage ROM_LAT-1 lines
    // up with the rom_q word belonging to that index.
    logic [IDX_W-1:0]    pipe_idx [ROM_LAT];
    logic [ROM_LAT-1:0]  pipe_vld;
    logic [ROM_LAT-1:0]  pipe_zero;

    logic                issue;
    logic [T_W-1:0]      t_n;
    logic [K_W-1:0]      k_n;
    logic [CHAR_LEN-1:0] tok_sel;
    logic                sel_zero;
    logic [ADDR_W-1:0]   addr_n;
    logic                last_wr;
    logic                wr_en;
    logic [SEQ_LEN-1:0]  err_n;

    always_comb begin
        state_n  = state;
        issue    = 1'b0;
        t_n      = cur_t;
        k_n      = cur_k;
        tok_sel  = tok_r[cur_t];
        last_wr  = pipe_vld[ROM_LAT-1] && (pipe_idx[ROM_LAT-1] == LAST_IDX);
        case (state)
            IDLE: begin
                if (run) begin
                    state_n = FETCH;
                    issue   = 1'b1;
                    t_n     = '0;
                    k_n     = '0;
                    tok_sel = d[CHAR_LEN-1:0];
                end
            end
            FETCH: begin
                if (!run) begin
                    state_n = IDLE;
                end else if (cur_idx == LAST_IDX) begin
                    state_n = DRAIN;
                end else begin
                    issue = 1'b1;
                    if (cur_k == LAST_K) begin
                        k_n = '0;
                        t_n = cur_t + 1'b1;
                    end else begin
                        k_n = cur_k + 1'b1;
                    end
                    tok_sel = tok_r[t_n];
                end
            end
            DRAIN: begin
                if (!run) begin
                    state_n = IDLE;
                end else if (last_wr) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (!run) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        sel_zero = tok_is_zero(tok_sel);
        // Zeroed tokens never use their data, so the address is parked at 0.
        addr_n   = sel_zero ? '0
                            : ADDR_W'(tok_sel) * ADDR_W'(EMB_DIM) + ADDR_W'(k_n);
    end

    always_comb begin
        err_n = '0;
        for (int t = 0; t < SEQ_LEN; t++) begin
            err_n[t] = tok_is_err(tok_r[t]);
        end
    end

    // Writes only while the lookup is live; an abort edge drops the word.
    assign wr_en = run && ((state == FETCH) || (state == DRAIN)) && pipe_vld[ROM_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rom_addr  <= '0;
            err       <= '0;
            q         <= '0;
            cur_idx   <= '0;
            cur_t     <= '0;
            cur_k     <= '0;
            iss_vld   <= 1'b0;
            iss_zero  <= 1'b0;
            pipe_vld  <= '0;
            pipe_zero <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_idx[i] <= '0;
            end
            for (int t = 0; t < SEQ_LEN; t++) begin
                tok_r[t] <= '0;
            end
        end else begin
            state <= state_n;
            if ((state == IDLE) && run) begin
                for (int t = 0; t < SEQ_LEN; t++) begin
                    tok_r[t] <= d[t*CHAR_LEN +: CHAR_LEN];
                end
            end
            if (issue) begin
                rom_addr <= addr_n;
                cur_idx  <= (state == IDLE) ? '0 : cur_idx + 1'b1;
                cur_t    <= t_n;
                cur_k    <= k_n;
                iss_zero <= sel_zero;
            end
            iss_vld <= issue;
            // Dropping run flushes every in-flight tag.
            pipe_vld[0]  <= iss_vld & run;
            pipe_idx[0]  <= cur_idx;
            pipe_zero[0] <= iss_zero;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1] & run;
                pipe_idx[i]  <= pipe_idx[i-1];
                pipe_zero[i] <= pipe_zero[i-1];
            end
            if (wr_en) begin
                q[int'(pipe_idx[ROM_LAT-1])*N_LEN +: N_LEN] <=
                    pipe_zero[ROM_LAT-1] ? '0 : rom_q;
            end
            if ((state == DRAIN) && (state_n == DONE)) begin
                err <= err_n;
            end
        end
    end

    assign busy      = (state == FETCH) || (state == DRAIN);
    assign valid     = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_emb_seq_block.sv
module tb_emb_seq_block;

    localparam int CL = 8;
    localparam int ED = 24;
    localparam int NL = 16;
    localparam int SL = 4;
    localparam int AW = 13;
    localparam int QW = SL * ED * NL;
    localparam int RW = QW + SL;
    localparam int LAT_A = 97;   // N + ROM_LAT with ROM_LAT = 1
    localparam int LAT_B = 99;   // N + ROM_LAT with ROM_LAT = 3

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (ROM_LAT = 1) ----------------
    logic              rst_a = 1'b1, run_a = 1'b0;
    logic [SL*CL-1:0]  d_a = '0;
    logic [AW-1:0]     rom_addr_a;
    logic [NL-1:0]     rom_q_a = '0;
    logic              busy_a, valid_a;
    logic [SL-1:0]     err_a;
    logic [QW-1:0]     q_a;
    logic [1:0]        st_a;

    emb_seq_block #(.ROM_LAT(1)) dut_a (
        .clk(clk), .rst(rst_a), .run(run_a), .d(d_a),
        .rom_addr(rom_addr_a), .rom_q(rom_q_a),
        .busy(busy_a), .valid(valid_a), .err(err_a), .q(q_a),
        .state_dbg(st_a)
    );

    always @(posedge clk) rom_q_a <= NL'(rom_addr_a);

    // ---------------- DUT B (ROM_LAT = 3) ----------------
    logic              rst_b = 1'b1, run_b = 1'b0;
    logic [SL*CL-1:0]  d_b = '0;
    logic [AW-1:0]     rom_addr_b, rb1 = '0, rb2 = '0;
    logic [NL-1:0]     rom_q_b = '0;
    logic              busy_b, valid_b;
    logic [SL-1:0]     err_b;
    logic [QW-1:0]     q_b;
    logic [1:0]        st_b;

    emb_seq_block #(.ROM_LAT(3)) dut_b (
        .clk(clk), .rst(rst_b), .run(run_b), .d(d_b),
        .rom_addr(rom_addr_b), .rom_q(rom_q_b),
        .busy(busy_b), .valid(valid_b), .err(err_b), .q(q_b),
        .state_dbg(st_b)
    );

    always @(posedge clk) begin
        rb1     <= rom_addr_b;
        rb2     <= rb1;
        rom_q_b <= NL'(rb2);
    end

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_a_q[$];
    logic [RW-1:0] exp_b_q[$];
    int            start_a_q[$];
    int            start_b_q[$];
    int            checks = 0;
    int            failures = 0;

    // Reference: element (t,k) = tok*24+k for in-range non-pad tokens, else 0.
    function automatic logic [RW-1:0] model(input logic [SL*CL-1:0] toks);
        logic [QW-1:0] qv;
        logic [SL-1:0] ev;
        int tk;
        qv = '0;
        ev = '0;
        for (int t = 0; t < SL; t++) begin
            tk = int'(toks[t*CL +: CL]);
            ev[t] = (tk >= 200);
            for (int k = 0; k < ED; k++) begin
                if (tk >= 200 || tk == 0) qv[(t*ED+k)*NL +: NL] = '0;
                else                      qv[(t*ED+k)*NL +: NL] = NL'(tk*ED + k);
            end
        end
        return {ev, qv};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int s = SL*ED-1; s >= 0; s--) begin
            if (act[s*NL +: NL] !== exp[s*NL +: NL]) bad = s;
        end
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s slot=%0d actual=%0d expected=%0d", name, bad,
                     act[bad*NL +: NL], exp[bad*NL +: NL]);
        end
    endtask

    // Monitor: pops an expectation whenever valid rises on either DUT.
    logic va_prev = 1'b0, vb_prev = 1'b0;
    always @(negedge clk) begin
        logic [RW-1:0] e;
        int s;
        if (valid_a && !va_prev) begin
            if (exp_a_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_valid actual=1 expected=0");
            end else begin
                e = exp_a_q.pop_front();
                s = start_a_q.pop_front();
                chk_q("a_q", q_a, e[QW-1:0]);
                chk("a_err", 64'(err_a), 64'(e[RW-1:QW]));
                chk("a_latency", 64'(cyc - s), 64'(LAT_A));
            end
        end
        if (valid_b && !vb_prev) begin
            if (exp_b_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_valid actual=1 expected=0");
            end else begin
                e = exp_b_q.pop_front();
                s = start_b_q.pop_front();
                chk_q("b_q", q_b, e[QW-1:0]);
                chk("b_err", 64'(err_b), 64'(e[RW-1:QW]));
                chk("b_latency", 64'(cyc - s), 64'(LAT_B));
            end
        end
        va_prev = valid_a;
        vb_prev = valid_b;
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after edge 0.
    task automatic start_a(input logic [SL*CL-1:0] toks, input bit push);
        d_a   = toks;
        run_a = 1'b1;
        if (push) begin
            exp_a_q.push_back(model(toks));
            start_a_q.push_back(cyc + 1);
        end
        @(negedge clk);
    endtask

    task automatic start_b(input logic [SL*CL-1:0] toks);
        d_b   = toks;
        run_b = 1'b1;
        exp_b_q.push_back(model(toks));
        start_b_q.push_back(cyc + 1);
        @(negedge clk);
    endtask

    task automatic wait_valid_a(input int budget);
        int n = 0;
        while (!valid_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!valid_a) begin
            checks++; failures++;
            $display("FAIL a_valid_timeout actual=0 expected=1");
        end
    endtask

    task automatic wait_valid_b(input int budget);
        int n = 0;
        while (!valid_b && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!valid_b) begin
            checks++; failures++;
            $display("FAIL b_valid_timeout actual=0 expected=1");
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_rom_addr"}, 64'(rom_addr_a), 64'd0);
        chk({tag, "_busy"},     64'(busy_a),     64'd0);
        chk({tag, "_valid"},    64'(valid_a),    64'd0);
        chk({tag, "_err"},      64'(err_a),      64'd0);
        chk({tag, "_state"},    64'(st_a),       64'd0);
        chk_q({tag, "_q"}, q_a, '0);
    endtask

    // ---------------- directed sequence ----------------
    logic [RW-1:0] basic_exp;

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_a("rst");
        rst_a = 1'b0;
        @(negedge clk);

        // Basic: tokens {5,1,199,42}
        basic_exp = model({8'd42, 8'd199, 8'd1, 8'd5});
        start_a({8'd42, 8'd199, 8'd1, 8'd5}, 1'b1);
        chk("basic_addr0", 64'(rom_addr_a), 64'd120);
        @(negedge clk);
        chk("basic_addr1", 64'(rom_addr_a), 64'd121);
        chk("basic_busy", 64'(busy_a), 64'd1);
        wait_valid_a(200);
        chk("basic_slot_2_23", 64'(q_a[(2*ED+23)*NL +: NL]), 64'd4799);
        chk("basic_err", 64'(err_a), 64'd0);

        // Hold: d changes are ignored while run stays high in DONE
        d_a = {8'd9, 8'd9, 8'd9, 8'd9};
        repeat (5) @(negedge clk);
        chk("hold_valid", 64'(valid_a), 64'd1);
        chk_q("hold_q", q_a, basic_exp[QW-1:0]);
        run_a = 1'b0;
        @(negedge clk);
        chk("release_valid", 64'(valid_a), 64'd0);
        chk_q("release_q", q_a, basic_exp[QW-1:0]);

        // Pad / range: tokens {0,250,3,200}
        start_a({8'd200, 8'd3, 8'd250, 8'd0}, 1'b1);
        wait_valid_a(200);
        chk("pad_err", 64'(err_a), 64'b1010);
        chk("pad_slot_2_0", 64'(q_a[(2*ED+0)*NL +: NL]), 64'd72);
        chk("pad_slot_2_23", 64'(q_a[(2*ED+23)*NL +: NL]), 64'd95);
        chk("pad_slot_1_5", 64'(q_a[(1*ED+5)*NL +: NL]), 64'd0);
        run_a = 1'b0;
        @(negedge clk);

        // Abort at edge 40, then restart with {7,7,7,7}
        start_a({8'd9, 8'd8, 8'd6, 8'd5}, 1'b0);
        repeat (39) @(negedge clk);
        run_a = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy_a), 64'd0);
        chk("abort_valid", 64'(valid_a), 64'd0);
        chk("abort_state", 64'(st_a), 64'd0);
        @(negedge clk);
        start_a({8'd7, 8'd7, 8'd7, 8'd7}, 1'b1);
        wait_valid_a(200);
        run_a = 1'b0;
        @(negedge clk);

        // Reset at edge 50 while run stays high
        start_a({8'd40, 8'd30, 8'd20, 8'd10}, 1'b0);
        repeat (49) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk_reset_a("midrst");
        rst_a = 1'b0;
        run_a = 1'b0;
        @(negedge clk);
        start_a({8'd1, 8'd199, 8'd150, 8'd100}, 1'b1);
        wait_valid_a(200);
        run_a = 1'b0;
        @(negedge clk);

        // ROM_LAT = 3 variant: tokens {1,2,3,4}
        rst_b = 1'b0;
        @(negedge clk);
        start_b({8'd4, 8'd3, 8'd2, 8'd1});
        wait_valid_b(200);
        chk("b_slot_3_23", 64'(q_b[(3*ED+23)*NL +: NL]), 64'd119);
        run_b = 1'b0;
        repeat (2) @(negedge clk);

        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL leftover_expectations actual=%0d expected=0",
                     exp_a_q.size() + exp_b_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
